// File: rtl/i_fetch_pkg.sv
// Pipeline-wide definitions for the fetch stage, shared with the decode stage.
package i_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  // Branch resolves in a later stage than jump, so it belongs to the older instruction.
  function automatic logic [31:0] redirect_target(
    input logic        branch_taken,
    input logic [31:0] branch_target,
    input logic [31:0] jump_target
  );
    return branch_taken ? branch_target : jump_target;
  endfunction

endpackage

// File: rtl/i_fetch_if_id_reg.sv
// IF/ID pipeline register: instruction, next-PC and valid with flush, hold and reset.
module if_id_reg import i_fetch_pkg::*; #(
  parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        hold,
  input  logic        vld_p0,
  input  logic [31:0] instr_p0,
  input  logic [31:0] npc_p0,
  output logic [31:0] instr_p1,
  output logic [31:0] npc_p1,
  output logic        vld_p1
);

  // IF -> ID boundary; flush beats hold, an empty slot becomes a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_p1 <= NOP_WORD;
      npc_p1   <= 32'h0;
      vld_p1   <= 1'b0;
    end else if (flush) begin
      instr_p1 <= NOP_WORD;
      vld_p1   <= 1'b0;
    end else if (!hold) begin
      if (vld_p0) begin
        instr_p1 <= instr_p0;
        npc_p1   <= npc_p0;
        vld_p1   <= 1'b1;
      end else begin
        instr_p1 <= NOP_WORD;
        vld_p1   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/i_fetch.sv
// Instruction fetch: PC, imem req/ready FSM, redirect handling and a 1-entry stall buffer
// in front of the IF/ID register.
module i_fetch import i_fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_INC    = i_fetch_pkg::PC_INC,
  parameter logic [31:0] NOP_INSTR = i_fetch_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_target_in,
  input  logic        jump_in,
  input  logic [31:0] jump_target_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ready_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] instruction_out,
  output logic [31:0] npc_out,
  output logic        valid_out
);

  fetch_state_e state_q, state_nxt;
  logic [31:0]  pc_q, pc_nxt;
  logic [31:0]  tgt_q, tgt_nxt;
  logic [31:0]  pc_plus;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         deliver;

  logic         hold_vld, hold_vld_nxt;
  logic [31:0]  hold_instr, hold_npc;

  logic         vld_p0;
  logic [31:0]  instr_p0, npc_p0;

  assign redirect    = branch_taken_in | jump_in;
  assign redirect_pc = redirect_target(branch_taken_in, branch_target_in, jump_target_in);
  assign pc_plus     = pc_q + PC_INC;
  assign deliver     = (state_q == WAIT) && imem_ready_in && !redirect;

  // The request is a pure function of state, so the address stays put until it completes.
  assign imem_req_out  = (state_q != FETCH);
  assign imem_addr_out = pc_q;

  always_comb begin
    state_nxt = state_q;
    pc_nxt    = pc_q;
    tgt_nxt   = tgt_q;
    unique case (state_q)
      FETCH: begin
        if (redirect)
          pc_nxt = redirect_pc;
        else if (!hold_vld)
          state_nxt = WAIT;
      end
      WAIT: begin
        if (redirect) begin
          if (imem_ready_in) begin
            pc_nxt    = redirect_pc;
            state_nxt = FETCH;
          end else begin
            tgt_nxt   = redirect_pc;
            state_nxt = DISCARD;
          end
        end else if (imem_ready_in) begin
          pc_nxt    = pc_plus;
          state_nxt = FETCH;
        end
      end
      DISCARD: begin
        // The outstanding read must still drain; only the newest target survives.
        if (redirect)
          tgt_nxt = redirect_pc;
        if (imem_ready_in) begin
          pc_nxt    = redirect ? redirect_pc : tgt_q;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    hold_vld_nxt = hold_vld;
    if (redirect)
      hold_vld_nxt = 1'b0;
    else if (deliver && stall_in)
      hold_vld_nxt = 1'b1;
    else if (!stall_in)
      hold_vld_nxt = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      hold_vld <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      pc_q     <= pc_nxt;
      hold_vld <= hold_vld_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    tgt_q <= tgt_nxt;
    if (deliver && stall_in) begin
      hold_instr <= imem_rdata_in;
      hold_npc   <= pc_plus;
    end
  end

  // Buffered word drains ahead of any new fetch once the stall lifts.
  assign vld_p0   = hold_vld | deliver;
  assign instr_p0 = hold_vld ? hold_instr : imem_rdata_in;
  assign npc_p0   = hold_vld ? hold_npc   : pc_plus;

  if_id_reg #(
    .NOP_WORD (NOP_INSTR)
  ) u_if_id (
    .clk      (CLK),
    .rst      (RST),
    .flush    (redirect),
    .hold     (stall_in),
    .vld_p0   (vld_p0),
    .instr_p0 (instr_p0),
    .npc_p0   (npc_p0),
    .instr_p1 (instruction_out),
    .npc_p1   (npc_out),
    .vld_p1   (valid_out)
  );

endmodule

// File: tb/tb_i_fetch.sv
// Directed bench for i_fetch: sequential fetch, slow memory, stall buffering, redirects, PC wrap.
module tb_i_fetch;

  localparam logic [31:0] K = 32'h012D_B820;

  logic        CLK = 1'b0;
  logic        RST, rst2;
  logic        stall_in, branch_taken_in, jump_in;
  logic [31:0] branch_target_in, jump_target_in;
  logic        imem_req_out, imem_ready_in, valid_out;
  logic [31:0] imem_addr_out, imem_rdata_in, instruction_out, npc_out;
  logic        req2, ready2, valid2;
  logic [31:0] addr2, rdata2, instr2, npc2;

  int lat = 0;
  int wait_cnt = 0;
  int n_chk = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  // Memory: mem[a] = a ^ K, ready after 'lat' waiting request cycles
  assign imem_ready_in = imem_req_out && (wait_cnt >= lat);
  assign imem_rdata_in = imem_addr_out ^ K;
  always @(posedge CLK)
    wait_cnt <= (imem_req_out && !imem_ready_in) ? wait_cnt + 1 : 0;

  assign ready2 = req2;
  assign rdata2 = addr2 ^ K;

  i_fetch dut (
    .CLK(CLK), .RST(RST), .stall_in(stall_in),
    .branch_taken_in(branch_taken_in), .branch_target_in(branch_target_in),
    .jump_in(jump_in), .jump_target_in(jump_target_in),
    .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_ready_in(imem_ready_in), .imem_rdata_in(imem_rdata_in),
    .instruction_out(instruction_out), .npc_out(npc_out), .valid_out(valid_out)
  );

  i_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .CLK(CLK), .RST(rst2), .stall_in(1'b0),
    .branch_taken_in(1'b0), .branch_target_in(32'h0),
    .jump_in(1'b0), .jump_target_in(32'h0),
    .imem_req_out(req2), .imem_addr_out(addr2),
    .imem_ready_in(ready2), .imem_rdata_in(rdata2),
    .instruction_out(instr2), .npc_out(npc2), .valid_out(valid2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!valid_out && n < budget);
    chk({tag, "_valid"}, {31'h0, valid_out}, 32'h1);
  endtask

  initial begin
    RST = 1'b1; rst2 = 1'b1; stall_in = 1'b0;
    branch_taken_in = 1'b0; jump_in = 1'b0;
    branch_target_in = 32'h0; jump_target_in = 32'h0;
    repeat (3) step();
    chk("rst_req",   {31'h0, imem_req_out}, 32'h0);
    chk("rst_valid", {31'h0, valid_out}, 32'h0);
    chk("rst_instr", instruction_out, 32'h0);
    chk("rst_npc",   npc_out, 32'h0);

    // Sequential fetch with zero-wait memory
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_valid(4, "seq");
      chk("seq_instr", instruction_out, (32'(i) * 4) ^ K);
      chk("seq_npc",   npc_out, 32'(i) * 4 + 4);
    end

    // Slow memory: address held over four request cycles
    lat = 3;
    step();
    for (int k = 0; k < 4; k++) begin
      chk("slow_req",   {31'h0, imem_req_out}, 32'h1);
      chk("slow_addr",  imem_addr_out, 32'd12);
      chk("slow_valid", {31'h0, valid_out}, 32'h0);
      step();
    end
    chk("slow_dvalid", {31'h0, valid_out}, 32'h1);
    chk("slow_instr",  instruction_out, 32'd12 ^ K);
    chk("slow_npc",    npc_out, 32'd16);

    // Stall while a response arrives
    lat = 1;
    stall_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stall_instr", instruction_out, 32'd12 ^ K);
      chk("stall_npc",   npc_out, 32'd16);
      chk("stall_valid", {31'h0, valid_out}, 32'h1);
      chk("stall_req",   {31'h0, imem_req_out}, (k < 2) ? 32'h1 : 32'h0);
    end
    stall_in = 1'b0;
    step();
    chk("unstall_instr", instruction_out, 32'd16 ^ K);
    chk("unstall_npc",   npc_out, 32'd20);
    chk("unstall_valid", {31'h0, valid_out}, 32'h1);
    chk("unstall_req",   {31'h0, imem_req_out}, 32'h0);
    step();
    chk("resume_req",  {31'h0, imem_req_out}, 32'h1);
    chk("resume_addr", imem_addr_out, 32'd20);

    // Jump during WAIT with the response still pending
    jump_in = 1'b1; jump_target_in = 32'h40;
    step();
    jump_in = 1'b0; jump_target_in = 32'h0;
    chk("jmp_flush_valid", {31'h0, valid_out}, 32'h0);
    chk("jmp_disc_req",    {31'h0, imem_req_out}, 32'h1);
    chk("jmp_disc_addr",   imem_addr_out, 32'd20);
    step();
    chk("jmp_drop_valid", {31'h0, valid_out}, 32'h0);
    chk("jmp_drop_req",   {31'h0, imem_req_out}, 32'h0);
    step();
    chk("jmp_req",  {31'h0, imem_req_out}, 32'h1);
    chk("jmp_addr", imem_addr_out, 32'h40);
    wait_valid(4, "jmp");
    chk("jmp_instr", instruction_out, 32'h40 ^ K);
    chk("jmp_npc",   npc_out, 32'h44);

    // Branch and jump together, ready in the same cycle
    lat = 0;
    step();
    chk("bj_addr", imem_addr_out, 32'h44);
    branch_taken_in = 1'b1; branch_target_in = 32'h80;
    jump_in = 1'b1; jump_target_in = 32'h40;
    step();
    branch_taken_in = 1'b0; jump_in = 1'b0;
    chk("bj_flush_valid", {31'h0, valid_out}, 32'h0);
    step();
    chk("bj_req",  {31'h0, imem_req_out}, 32'h1);
    chk("bj_addr2", imem_addr_out, 32'h80);
    step();
    chk("bj_instr", instruction_out, 32'h80 ^ K);
    chk("bj_npc",   npc_out, 32'h84);

    // PC wrap from the top of the address space, then reset mid-request
    rst2 = 1'b0;
    step();
    chk("wrap_req0",  {31'h0, req2}, 32'h1);
    chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
    step();
    chk("wrap_instr", instr2, 32'hFFFF_FFFC ^ K);
    chk("wrap_npc",   npc2, 32'h0);
    chk("wrap_valid", {31'h0, valid2}, 32'h1);
    step();
    chk("wrap_addr1", addr2, 32'h0);
    rst2 = 1'b1;
    step();
    chk("rstw_req",   {31'h0, req2}, 32'h0);
    chk("rstw_valid", {31'h0, valid2}, 32'h0);
    chk("rstw_instr", instr2, 32'h0);
    rst2 = 1'b0;
    step();
    chk("rstw_addr", addr2, 32'hFFFF_FFFC);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
